branch_resolve_queue: RTL and testbench

//  In-order queue of in-flight branch predictions between IF and EX.
//  IF pushes {pc, predicted-taken, global history}; EX pops the oldest entry on resolution.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_meta_fifo.sv | 58 +++++
 rtl/branch_resolve_queue.sv | 86 ++++++++
 tb/tb_branch_resolve_queue.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch resolve queue: per-branch metadata and PC step.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_pkg;

  localparam int BP_N     = 128;
  localparam int BP_HW    = $clog2(BP_N);
  localparam int BP_PCW   = 32;
  localparam int BP_DEPTH = 4;

  localparam logic [BP_PCW-1:0] BP_PC_STEP = BP_PCW'(4);

  typedef struct packed {
    logic [BP_PCW-1:0] pc;
    logic              pred_taken;
    logic [BP_HW-1:0]  bhr;
  } bp_meta_t;

  // Fall-through fetch address after a not-taken branch; wraps at PCW bits.
  function automatic logic [BP_PCW-1:0] bp_next_pc(input logic [BP_PCW-1:0] pc);
    return pc + BP_PC_STEP;
  endfunction

endpackage

// File: rtl/bp_meta_fifo.sv
// Circular buffer of branch metadata; head is visible combinationally at rd_ptr.
// Latency: push visible at head one cycle later; clear takes effect at the next edge.
// Backpressure: none internally; caller must not push when full or pop when empty.
module bp_meta_fifo
  import bp_pkg::*;
#(
  parameter  int DEPTH = BP_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  bp_meta_t      push_dat,
  input  logic          pop,
  input  logic          clear,
  output bp_meta_t      head,
  output logic [CW-1:0] count
);

  bp_meta_t      mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  assign head = mem[rd_ptr];

  // Storage carries no reset: validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions between IF and EX with mispredict redirect.
// Latency: predictor update port is combinational on resolve; redirect is registered (1 cycle).
// Backpressure: push_ready drops when full (no same-cycle pop bypass); resolves on empty are ignored.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter  int N     = BP_N,
  parameter  int DEPTH = BP_DEPTH,
  parameter  int PCW   = BP_PCW,
  localparam int HW    = $clog2(N),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_valid,
  input  logic [PCW-1:0] push_pc,
  input  logic           push_pred_taken,
  input  logic [HW-1:0]  push_bhr,
  output logic           push_ready,
  input  logic           resolve_valid,
  input  logic           resolve_taken,
  input  logic [PCW-1:0] resolve_target,
  input  logic           flush,
  output logic           is_branch_ex,
  output logic           cmp_out_ex,
  output logic [HW-1:0]  bhr_ex,
  output logic           mispredict,
  output logic [PCW-1:0] redirect_pc,
  output logic [CW-1:0]  count
);

  bp_meta_t      head;
  bp_meta_t      push_meta;
  logic [CW-1:0] fifo_count;
  logic          pop_req;
  logic          mp;
  logic          kill;
  logic          fifo_push;
  logic          fifo_pop;

  assign push_meta = '{pc: push_pc, pred_taken: push_pred_taken, bhr: push_bhr};

  assign count      = fifo_count;
  assign push_ready = (fifo_count != CW'(DEPTH));
  assign pop_req    = resolve_valid && (fifo_count != '0);
  assign mp         = pop_req && (resolve_taken != head.pred_taken);

  // Any mispredicting pop or external flush discards the whole wrong path,
  // including whatever IF offers this cycle.
  assign kill       = flush || mp;
  assign fifo_push  = push_valid && push_ready && !kill;
  assign fifo_pop   = pop_req && !kill;

  // The predictor trains on every real resolve, even one that a flush discards.
  assign is_branch_ex = pop_req;
  assign cmp_out_ex   = resolve_taken;
  assign bhr_ex       = head.bhr;

  bp_meta_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (push_meta),
    .pop      (fifo_pop),
    .clear    (kill),
    .head     (head),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mp && !flush;
      if (mp && !flush) begin
        redirect_pc <= resolve_taken ? resolve_target : bp_next_pc(head.pc);
      end
    end
  end

  // After a redirect the queue is empty, so a second consecutive pulse is impossible.
  a_mp_single: assert property (@(posedge clk) disable iff (rst) mispredict |=> !mispredict);
  a_count_max: assert property (@(posedge clk) disable iff (rst) fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench: queue-based reference model compared against the DUT every cycle.
// Directed scenarios with literal pins, then randomized push/resolve/flush traffic.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int HW    = 7;
  localparam int PCW   = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           push_valid;
  logic [PCW-1:0] push_pc;
  logic           push_pred_taken;
  logic [HW-1:0]  push_bhr;
  logic           push_ready;
  logic           resolve_valid;
  logic           resolve_taken;
  logic [PCW-1:0] resolve_target;
  logic           flush;
  logic           is_branch_ex;
  logic           cmp_out_ex;
  logic [HW-1:0]  bhr_ex;
  logic           mispredict;
  logic [PCW-1:0] redirect_pc;
  logic [2:0]     count;

  branch_resolve_queue dut (
    .clk             (clk),
    .rst             (rst),
    .push_valid      (push_valid),
    .push_pc         (push_pc),
    .push_pred_taken (push_pred_taken),
    .push_bhr        (push_bhr),
    .push_ready      (push_ready),
    .resolve_valid   (resolve_valid),
    .resolve_taken   (resolve_taken),
    .resolve_target  (resolve_target),
    .flush           (flush),
    .is_branch_ex    (is_branch_ex),
    .cmp_out_ex      (cmp_out_ex),
    .bhr_ex          (bhr_ex),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .count           (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [6:0]  bhr;
  } ent_t;

  ent_t        q[$];
  bit          m_mp;
  logic [31:0] m_redir;
  int          n_vec;
  int          n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit exp_pop;
    exp_pop = resolve_valid && (q.size() != 0);
    chk("push_ready", 32'(push_ready), 32'(q.size() != DEPTH));
    chk("count", 32'(count), 32'(q.size()));
    chk("is_branch_ex", 32'(is_branch_ex), 32'(exp_pop));
    chk("cmp_out_ex", 32'(cmp_out_ex), 32'(resolve_taken));
    if (exp_pop) chk("bhr_ex", 32'(bhr_ex), 32'(q[0].bhr));
    chk("mispredict", 32'(mispredict), 32'(m_mp));
    chk("redirect_pc", redirect_pc, m_redir);
  endtask

  // Applies the queue rules to whatever inputs are held across the edge.
  task automatic model_update();
    int sz;
    bit pop;
    bit push_ok;
    sz      = q.size();
    pop     = resolve_valid && (sz > 0);
    push_ok = push_valid && (sz != DEPTH);
    if (flush) begin
      q.delete();
      m_mp = 1'b0;
    end else if (pop && (resolve_taken != q[0].pt)) begin
      m_redir = resolve_taken ? resolve_target : q[0].pc + 32'd4;
      m_mp    = 1'b1;
      q.delete();
    end else begin
      m_mp = 1'b0;
      if (pop) void'(q.pop_front());
      if (push_ok) q.push_back('{pc: push_pc, pt: push_pred_taken, bhr: push_bhr});
    end
  endtask

  task automatic drive(input logic a_pv, input logic [31:0] a_pc, input logic a_pt,
                       input logic [6:0] a_bhr, input logic a_rv, input logic a_rt,
                       input logic [31:0] a_tgt, input logic a_fl);
    push_valid      = a_pv;
    push_pc         = a_pc;
    push_pred_taken = a_pt;
    push_bhr        = a_bhr;
    resolve_valid   = a_rv;
    resolve_taken   = a_rt;
    resolve_target  = a_tgt;
    flush           = a_fl;
    #1;
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_mp = 1'b0;
    m_redir = '0;
    rst = 1'b1;
    push_valid = 0; push_pc = 0; push_pred_taken = 0; push_bhr = 0;
    resolve_valid = 0; resolve_taken = 0; resolve_target = 0; flush = 0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(push_ready), 1);
    chk("rst_mispredict", 32'(mispredict), 0);
    chk("rst_redirect", redirect_pc, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: fill to DEPTH, then a refused fifth push
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 0, 7'(8'h10 + i), 0, 0, 0, 0);
      tick();
    end
    drive(1, 32'h110, 0, 7'h55, 0, 0, 0, 0);
    chk("t1_full_count", 32'(count), 4);
    chk("t1_full_ready", 32'(push_ready), 0);
    tick();
    idle();
    chk("t1_count_stays", 32'(count), 4);

    // 2: four correct not-taken resolves, history in push order
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, 32'hdead0000, 0);
      chk("t2_strobe", 32'(is_branch_ex), 1);
      chk("t2_bhr", 32'(bhr_ex), 32'h10 + 32'(i));
      tick();
      chk("t2_no_mp", 32'(mispredict), 0);
    end
    idle();
    chk("t2_empty", 32'(count), 0);

    // 3: taken mispredict redirects to the computed target
    drive(1, 32'h200, 0, 7'h21, 0, 0, 0, 0); tick();
    drive(1, 32'h204, 1, 7'h22, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 1, 32'h380, 0); tick();
    idle();
    chk("t3_mispredict", 32'(mispredict), 1);
    chk("t3_redirect", redirect_pc, 32'h380);
    chk("t3_count", 32'(count), 0);
    tick();
    idle();
    chk("t3_pulse_ends", 32'(mispredict), 0);
    chk("t3_redirect_held", redirect_pc, 32'h380);

    // 4: not-taken mispredict falls through to pc+4; same-cycle push dropped
    drive(1, 32'h3FC, 1, 7'h33, 0, 0, 0, 0); tick();
    drive(1, 32'h500, 0, 7'h44, 1, 0, 32'h9000, 0); tick();
    idle();
    chk("t4_redirect", redirect_pc, 32'h400);
    chk("t4_count", 32'(count), 0);
    tick();

    // 5: resolve on empty queue is ignored
    drive(0, 0, 0, 0, 1, 1, 32'h777, 0);
    chk("t5_no_strobe", 32'(is_branch_ex), 0);
    tick();
    idle();
    chk("t5_no_mp", 32'(mispredict), 0);

    // flush beats mispredict: predictor still strobes, no redirect
    drive(1, 32'h600, 0, 7'h61, 0, 0, 0, 0); tick();
    drive(1, 32'h604, 0, 7'h62, 1, 1, 32'h1234, 1);
    chk("fl_strobe", 32'(is_branch_ex), 1);
    tick();
    idle();
    chk("fl_no_mp", 32'(mispredict), 0);
    chk("fl_redirect_kept", redirect_pc, 32'h400);
    chk("fl_count", 32'(count), 0);

    // 6: async reset with three entries in flight
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h700 + 32'(4 * i), 0, 7'(i), 0, 0, 0, 0);
      tick();
    end
    idle();
    chk("t6_pre_count", 32'(count), 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_mp", 32'(mispredict), 0);
    chk("t6_rst_ready", 32'(push_ready), 1);
    q.delete();
    m_mp = 1'b0;
    m_redir = '0;
    @(negedge clk);
    rst = 1'b0;

    // pointer wrap: six push+pop cycles with one entry in flight
    drive(1, 32'h800, 0, 7'h40, 0, 0, 0, 0); tick();
    for (int i = 1; i <= 6; i++) begin
      drive(1, 32'h800 + 32'(4 * i), 1'($urandom_range(0, 1)), 7'(8'h40 + i), 1, q[0].pt, 0, 0);
      chk("wrap_bhr", 32'(bhr_ex), 32'h40 + 32'(i - 1));
      tick();
    end
    drive(0, 0, 0, 0, 1, q[0].pt, 0, 0); tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic rt;
      rt = 1'($urandom_range(0, 1));
      if (q.size() != 0 && ($urandom_range(0, 3) != 0)) rt = q[0].pt;
      drive(1'($urandom_range(0, 3) != 0), {$urandom()} & 32'hffff_fffc,
            1'($urandom_range(0, 1)), 7'($urandom()), 1'($urandom_range(0, 2) == 0),
            rt, $urandom(), 1'($urandom_range(0, 40) == 0));
      tick();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
